// File: rtl/collector_pkg.sv
// Shared definitions for the serial-to-parallel collector: FSM encoding,
// legal width range and the width-to-counter-size helper.
package collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int W_MIN = 2;
  localparam int W_MAX = 16;

  // The bit counter must hold 0..W-1 while collecting; log2(W)+1 bits
  // also leaves room to represent W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/collector_shreg.sv
// W-bit right-shift register, serial data enters at the MSB.
// nxt exposes the value the register takes on an enabled shift, so the
// controller can capture a completed word on the same edge as the last bit.
module collector_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic         sin,
  output logic [W-1:0] d,
  output logic [W-1:0] nxt
);

  // Next value on an enabled shift: new bit in at the top, older bits move down.
  always_comb begin
    nxt = {sin, d[W-1:1]};
  end

  // Register update; clear beats shift so a completed or aborted word starts clean.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      d <= '0;
    end else if (clr) begin
      d <= '0;
    end else if (en) begin
      d <= nxt;
    end
  end

endmodule

// File: rtl/shift_collector.sv
// Serial-to-parallel word collector with consumer handshake.
// Bits arrive LSB first on sis while ebl=1; after W bits the word is
// presented on Q with vld until ack. Bits arriving while a word waits are
// dropped and flagged on the sticky ovf.
//
//  state | meaning
//  IDLE  | no bits of the current word collected yet
//  SHIFT | partial word in progress (cnt = bits collected so far)
//  FULL  | complete word on Q, vld=1, waiting for ack
module shift_collector
  import collector_pkg::*;
#(
  parameter int W = 8,
  localparam int CW = cnt_width(W)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sis,
  input  logic          ebl,
  input  logic          abt,
  input  logic          ack,
  output logic [W-1:0]  Q,
  output logic          vld,
  output logic          ovf,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (W < W_MIN || W > W_MAX) begin : g_bad_width
    $error("shift_collector: W out of range 2..16");
  end

  state_t       state;
  logic         shift_en;
  logic         clr_en;
  logic [W-1:0] sr_d;
  logic [W-1:0] sr_nxt;

  collector_shreg #(.W(W)) u_shreg (
    .clk  (clk),
    .rstn (rstn),
    .en   (shift_en),
    .clr  (clr_en),
    .sin  (sis),
    .d    (sr_d),
    .nxt  (sr_nxt)
  );

  // Datapath control: when to shift a bit in and when to wipe the register.
  // In FULL the register is already clear (wiped on entry), so a bit taken
  // together with ack becomes bit 0 of the next word after W-1 more shifts.
  always_comb begin
    shift_en = 1'b0;
    clr_en   = 1'b0;
    case (state)
      IDLE, SHIFT: begin
        if (abt) begin
          clr_en = 1'b1;
        end else if (ebl) begin
          shift_en = 1'b1;
          if (cnt == CNT_LAST) begin
            clr_en = 1'b1;
          end
        end
      end
      FULL: begin
        shift_en = ack & ebl;
      end
      default: begin
        clr_en = 1'b1;
      end
    endcase
  end

  // Collection FSM with registered outputs: state, bit counter, word, flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      Q     <= '0;
      vld   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (abt) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (ebl) begin
            if (cnt == CNT_LAST) begin
              Q     <= sr_nxt;
              vld   <= 1'b1;
              cnt   <= '0;
              state <= FULL;
            end else begin
              cnt   <= cnt + CNT_ONE;
              state <= SHIFT;
            end
          end
        end
        FULL: begin
          // abt is deliberately not looked at here: a finished word is kept.
          if (ack) begin
            vld <= 1'b0;
            if (ebl) begin
              cnt   <= CNT_ONE;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else if (ebl) begin
            ovf <= 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_collector.sv
module tb_shift_collector;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rstn;
  logic          sis;
  logic          ebl;
  logic          abt;
  logic          ack;
  logic [W-1:0]  Q;
  logic          vld;
  logic          ovf;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  shift_collector #(.W(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .sis  (sis),
    .ebl  (ebl),
    .abt  (abt),
    .ack  (ack),
    .Q    (Q),
    .vld  (vld),
    .ovf  (ovf),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rstn;
    logic         ebl;
    logic         sis;
    logic         abt;
    logic         ack;
    logic [W-1:0] q;
    logic         vld;
    logic         ovf;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic s, input logic a,
                     input logic k, input logic [W-1:0] q, input logic v,
                     input logic o, input int c);
    vec_t x;
    x.rstn = r; x.ebl = e; x.sis = s; x.abt = a; x.ack = k;
    x.q = q; x.vld = v; x.ovf = o; x.cnt = CW'(c);
    tbl.push_back(x);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic s,
                       input logic a, input logic k);
    rstn = r; ebl = e; sis = s; abt = a; ack = k;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of collected bits, a presented word, flags.
  bit           m_bits[$];
  logic [W-1:0] m_q;
  bit           m_vld;
  bit           m_ovf;

  function automatic logic [W-1:0] word_of(input bit b[$]);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < b.size(); i++) if (b[i]) w = w | (W'(1) << i);
    return w;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit s,
                            input bit a, input bit k);
    if (!r) begin
      m_bits.delete(); m_q = '0; m_vld = 0; m_ovf = 0;
    end else if (m_vld) begin
      if (k) begin
        m_vld = 0;
        m_bits.delete();
        if (e) m_bits.push_back(s);
      end else if (e) begin
        m_ovf = 1;
      end
    end else if (a) begin
      m_bits.delete();
    end else if (e) begin
      m_bits.push_back(s);
      if (m_bits.size() == W) begin
        m_q = word_of(m_bits);
        m_vld = 1;
        m_bits.delete();
      end
    end
  endtask

  initial begin
    bit cap[8];
    bit b2b[7];
    bit ab5[5];
    bit w02[8];
    rstn = 0; ebl = 0; sis = 0; abt = 0; ack = 0;

    cap = '{1, 0, 1, 1, 1, 0, 0, 1};
    b2b = '{0, 0, 0, 0, 0, 0, 0};
    ab5 = '{1, 1, 0, 0, 1};
    w02 = '{0, 1, 0, 0, 0, 0, 0, 0};

    // reset state
    add(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // word capture
    for (int i = 0; i < 7; i++) add(1, 1, cap[i], 0, 0, 8'h00, 0, 0, i + 1);
    add(1, 1, cap[7], 0, 0, 8'h9D, 1, 0, 0);
    add(1, 0, 0, 0, 0, 8'h9D, 1, 0, 0);
    add(1, 0, 0, 0, 1, 8'h9D, 0, 0, 0);
    // gapped enable
    for (int i = 0; i < 4; i++) add(1, 1, cap[i], 0, 0, 8'h9D, 0, 0, i + 1);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 8'h9D, 0, 0, 4);
    for (int i = 4; i < 7; i++) add(1, 1, cap[i], 0, 0, 8'h9D, 0, 0, i + 1);
    add(1, 1, cap[7], 0, 0, 8'h9D, 1, 0, 0);
    // overflow, abort ignored in FULL
    add(1, 1, 1, 0, 0, 8'h9D, 1, 1, 0);
    add(1, 0, 0, 1, 0, 8'h9D, 1, 1, 0);
    add(1, 1, 0, 1, 0, 8'h9D, 1, 1, 0);
    // back-to-back ack + bit
    add(1, 1, 1, 0, 1, 8'h9D, 0, 1, 1);
    for (int i = 0; i < 6; i++) add(1, 1, b2b[i], 0, 0, 8'h9D, 0, 1, i + 2);
    add(1, 1, b2b[6], 0, 0, 8'h01, 1, 1, 0);
    add(1, 0, 0, 0, 1, 8'h01, 0, 1, 0);
    // ack outside FULL ignored; abort at cnt=5 with ebl=1
    for (int i = 0; i < 5; i++) add(1, 1, ab5[i], 0, i == 2, 8'h01, 0, 1, i + 1);
    add(1, 1, 1, 1, 0, 8'h01, 0, 1, 0);
    add(1, 0, 0, 0, 0, 8'h01, 0, 1, 0);
    for (int i = 0; i < 7; i++) add(1, 1, w02[i], 0, 0, 8'h01, 0, 1, i + 1);
    add(1, 1, w02[7], 0, 0, 8'h02, 1, 1, 0);
    // reset in FULL with everything asserted
    add(0, 1, 1, 1, 1, 8'h00, 0, 0, 0);
    // first edge after reset accepts a bit
    add(1, 1, 1, 0, 0, 8'h00, 0, 0, 1);
    add(1, 1, 0, 0, 0, 8'h00, 0, 0, 2);
    // reset mid-word
    add(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rstn, tbl[i].ebl, tbl[i].sis, tbl[i].abt, tbl[i].ack);
      check($sformatf("tbl%0d.q", i),   Q,   tbl[i].q);
      check($sformatf("tbl%0d.vld", i), vld, tbl[i].vld);
      check($sformatf("tbl%0d.ovf", i), ovf, tbl[i].ovf);
      check($sformatf("tbl%0d.cnt", i), cnt, tbl[i].cnt);
    end

    // Hand sequence: shortest path to FULL and straight back out with ack.
    apply(0, 0, 0, 0, 0);
    for (int i = 0; i < W; i++) apply(1, 1, 1, 0, 0);
    check("seq_allones.q", Q, 8'hFF);
    check("seq_allones.vld", vld, 1);
    apply(1, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 1);
    check("seq_ackidle.vld", vld, 0);
    check("seq_ackidle.cnt", cnt, 0);

    // Randomized run against the reference model.
    m_bits.delete(); m_q = '0; m_vld = 0; m_ovf = 0;
    apply(0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, e, s, a, k;
      r = ($urandom_range(0, 99) >= 2);
      e = ($urandom_range(0, 99) < 70);
      s = $urandom_range(0, 1);
      a = ($urandom_range(0, 99) < 4);
      k = ($urandom_range(0, 99) < 25);
      apply(r, e, s, a, k);
      model_step(r, e, s, a, k);
      check($sformatf("rnd%0d.q", n),   Q,   m_q);
      check($sformatf("rnd%0d.vld", n), vld, m_vld);
      check($sformatf("rnd%0d.ovf", n), ovf, m_ovf);
      check($sformatf("rnd%0d.cnt", n), cnt, m_bits.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_collector.md
SHIFT_COLLECTOR -- requirements
Module: shift_collector

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the assembled word width; legal range is 2..16.
REQ-002 clk  input  1  The block SHALL use clk as its single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  The block SHALL treat rstn as a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 sis  input  1  The block SHALL take sis as serial data in, LSB of the word first.
REQ-005 ebl  input  1  The block SHALL sample sis only when ebl=1.
REQ-006 abt  input  1  The block SHALL use abt as a synchronous abort that discards a partial word.
REQ-007 ack  input  1  The block SHALL use ack as the consumer acknowledge for a presented word.
REQ-008 Q  output  W  The block SHALL present the assembled parallel word on Q.
REQ-009 vld  output  1  The block SHALL drive vld=1 while Q holds a complete, unacknowledged word.
REQ-010 ovf  output  1  The block SHALL drive ovf as a sticky flag for a bit dropped while full.
REQ-011 cnt  output  log2(W)+1  The block SHALL expose the number of bits collected in the current word on cnt.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT, FULL.
REQ-013 The block SHALL, on each edge with ebl=1 in IDLE or SHIFT, shift sis into the MSB of an internal W-bit shift register, shift the register right by one, and increment cnt.
REQ-014 The block SHALL move from IDLE to SHIFT on the first accepted bit (cnt=1).
REQ-015 The block SHALL, on the edge accepting the W-th bit, load Q with the full word, set vld=1, clear cnt to 0, and enter FULL; vld is visible on the following cycle, so latency is 1 clock from the last bit's edge.
REQ-016 The block SHALL hold Q and vld stable in FULL until ack=1 is sampled.
REQ-017 The block SHALL, on ack=1 in FULL, clear vld and enter IDLE; ack outside FULL SHALL be ignored.
REQ-018 The block SHALL, on ebl=1 and ack=1 in the same FULL cycle, accept the bit as bit 0 of the next word (cnt=1, state SHIFT, vld=0).
REQ-019 The block SHALL, on ebl=1 with ack=0 in FULL, drop the bit, set ovf=1, and leave Q, vld, and cnt unchanged.
REQ-020 The block SHALL, on abt=1 in IDLE or SHIFT, clear cnt and the shift register and enter IDLE; abt has priority over ebl in the same cycle.
REQ-021 The block SHALL ignore abt in FULL, so a complete word is never discarded.
REQ-022 The block SHALL clear ovf only by reset.
REQ-023 The block SHALL leave Q unchanged in IDLE and SHIFT; Q changes only on entry to FULL or on reset.

Reset
REQ-024 The block SHALL, on rstn=0 at a clk edge, force state=IDLE, Q=0, vld=0, ovf=0, cnt=0, and shift register=0, regardless of ebl, abt, ack, or the current state, including mid-word and in FULL.
REQ-025 The block SHALL accept a bit on the first edge after rstn returns to 1 if ebl=1.

Structure
REQ-026 The state encoding (IDLE=2'd0, SHIFT=2'd1, FULL=2'd2) SHALL reside in a shared package, collector_pkg, alongside the width-to-counter-size constant.
REQ-027 The datapath SHALL be one sub-module, collector_shreg, a W-bit right-shift register with serial-in at the MSB, shift enable, and synchronous clear; the FSM, counter, and flags SHALL be in shift_collector.

Verification
REQ-028 A bench SHALL cover the following directed scenarios:
- Word capture: W=8, ebl=1 for 8 cycles, sis LSB-first of 8'b10011101 (1,0,1,1,1,0,0,1) -> vld=1 one cycle after the 8th edge, Q=8'h9D, cnt=0.
- Gapped enable: same word with ebl deasserted for 3 cycles after bit 4 -> cnt holds at 4 during the gap; result Q=8'h9D.
- Overflow: in FULL with ack=0, pulse ebl=1 with sis=1 -> ovf=1, Q stays 8'h9D, vld stays 1; a later ack -> vld=0, ovf stays 1.
- Back-to-back: ack=1 and ebl=1 (sis=1) in the same cycle -> vld=0, cnt=1, state SHIFT; 7 more bits give Q=8'h01 for sis pattern 1,0,0,0,0,0,0,0.
- Abort and reset: abt=1 with ebl=1 at cnt=5 -> cnt=0, IDLE, Q unchanged; separately, rstn=0 in FULL -> Q=0, vld=0, ovf=0 on the next edge.
